// File: rtl/branch_lut_pkg.sv
// -----------------------------------------------------------------------------
// branch_lut_pkg
//   Shared definitions for the branch-target lookup table:
//     N_DEFAULTS       number of keys that carry a valid default target
//     DEFAULT_TARGETS  default jump targets for keys 0..N_DEFAULTS-1
//     state_t          table controller states (ST_INIT walks the table,
//                      ST_IDLE serves lookups and writes)
//     default_target() default data for any table index (0 beyond the list)
//     default_valid()  default valid bit for any table index
// -----------------------------------------------------------------------------
package branch_lut_pkg;

  localparam int unsigned N_DEFAULTS = 18;
  localparam int unsigned DIDX_W     = $clog2(N_DEFAULTS);

  localparam logic [31:0] DEFAULT_TARGETS [N_DEFAULTS] = '{
    32'd32,  32'd33,  32'd34,  32'd35,  32'd60,  32'd64,
    32'd91,  32'd109, 32'd128, 32'd142, 32'd168, 32'd170,
    32'd200, 32'd204, 32'd224, 32'd232, 32'd240, 32'd254
  };

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  // Callers cast the result to their address width, which zero-extends
  // narrow defaults and keeps only the LSBs of wide ones.
  function automatic logic [31:0] default_target(input int unsigned idx);
    if (idx < N_DEFAULTS) return DEFAULT_TARGETS[idx[DIDX_W-1:0]];
    return '0;
  endfunction

  function automatic logic default_valid(input int unsigned idx);
    return idx < N_DEFAULTS;
  endfunction

endpackage

// File: rtl/branch_lut_mem.sv
// -----------------------------------------------------------------------------
// branch_lut_mem
//   Single-write, single-registered-read table of DEPTH = 2**KEY_W entries,
//   each ADDR_W data bits plus a valid bit. A write and a read to the same key
//   in the same cycle forward the write to the read result.
//
//   Ports:
//     clk, reset_n     clock, asynchronous active-low reset (clears valid bits
//                      and the read result)
//     wr_en            write strobe
//     wr_key           entry index to write
//     wr_data          data to store
//     wr_valid         valid bit to store
//     rd_en            capture a new read result this cycle
//     rd_blank         force the captured result to a miss
//     rd_key           entry index to read
//     rd_addr          registered result: data when valid, else 0
//     rd_hit           registered result: entry valid
// -----------------------------------------------------------------------------
module branch_lut_mem #(
  parameter int KEY_W  = 5,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic              wr_valid,
  input  logic              rd_en,
  input  logic              rd_blank,
  input  logic [KEY_W-1:0]  rd_key,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit
);

  localparam int DEPTH = 2 ** KEY_W;

  logic [ADDR_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic              fwd;
  logic              hit_d;
  logic [ADDR_W-1:0] addr_d;

  // NOTE: the data array has no reset so it can map onto RAM/ROM; only the
  // valid bits need a known value, and they alone gate what a lookup returns.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_key] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_key] <= wr_valid;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    fwd    = wr_en && (wr_key == rd_key);
    hit_d  = 1'b0;
    addr_d = '0;
    if (!rd_blank) begin
      if (fwd) begin
        hit_d  = wr_valid;
        addr_d = wr_valid ? wr_data : '0;
      end else if (valid_q[rd_key]) begin
        hit_d  = 1'b1;
        addr_d = data_q[rd_key];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr <= '0;
      rd_hit  <= 1'b0;
    end else if (rd_en) begin
      rd_addr <= addr_d;
      rd_hit  <= hit_d;
    end
  end

endmodule

// File: rtl/branch_lut.sv
// -----------------------------------------------------------------------------
// branch_lut
//   Branch-target lookup table. A KEY_W-bit key maps to an ADDR_W-bit jump
//   target through a one-cycle registered read. After reset, and on init_req,
//   the controller walks every entry (one per cycle) loading the defaults;
//   lookups during that walk complete as misses.
//
//   Build option: define BRANCH_LUT_WRITE_EN to enable run-time writes via
//   the prog_* valid/ready port. Without it prog_ready is tied low and the
//   table only ever holds its defaults.
//
//   Ports:
//     clk            clock
//     reset_n        asynchronous active-low reset
//     lk_valid       lookup request
//     lk_key         lookup key
//     lk_out_valid   result valid, one cycle after lk_valid
//     lk_addr        target address (0 on miss), held between results
//     lk_hit         entry was valid, held between results
//     prog_valid     write request
//     prog_ready     write accepted when prog_valid && prog_ready
//     prog_key       entry to write
//     prog_addr      target to store
//     init_req       one-cycle pulse: reload defaults
//     busy           default reload in progress
// -----------------------------------------------------------------------------
module branch_lut
  import branch_lut_pkg::*;
#(
  parameter int KEY_W  = 5,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              lk_valid,
  input  logic [KEY_W-1:0]  lk_key,
  output logic              lk_out_valid,
  output logic [ADDR_W-1:0] lk_addr,
  output logic              lk_hit,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [KEY_W-1:0]  prog_key,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic              init_req,
  output logic              busy
);

  localparam int               DEPTH    = 2 ** KEY_W;
  localparam logic [KEY_W-1:0] LAST_IDX = KEY_W'(DEPTH - 1);

  state_t            state;
  logic [KEY_W-1:0]  idx;
  logic              prog_fire;

  logic              wr_en;
  logic [KEY_W-1:0]  wr_key;
  logic [ADDR_W-1:0] wr_data;
  logic              wr_valid;

  // Controller: INIT covers exactly DEPTH cycles (index 0..DEPTH-1); busy is
  // registered alongside the state so it drops on the cycle IDLE is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      idx   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (idx == LAST_IDX) begin
            state <= ST_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
          end else begin
            idx <= idx + KEY_W'(1);
          end
        end
        ST_IDLE: begin
          if (init_req) begin
            state <= ST_INIT;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= ST_INIT;
          idx   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

`ifdef BRANCH_LUT_WRITE_EN
  // A reload request takes priority: no write is accepted in its cycle.
  assign prog_ready = (state == ST_IDLE) && !init_req;
  assign prog_fire  = prog_valid && prog_ready;
`else
  logic unused_prog;
  assign unused_prog = prog_valid;
  assign prog_ready  = 1'b0;
  assign prog_fire   = 1'b0;
`endif

  // Write port owner: the INIT walk while busy, the prog port otherwise.
  always_comb begin
    wr_en    = prog_fire;
    wr_key   = prog_key;
    wr_data  = prog_addr;
    wr_valid = 1'b1;
    if (state == ST_INIT) begin
      wr_en    = 1'b1;
      wr_key   = idx;
      wr_data  = ADDR_W'(default_target(32'(idx)));
      wr_valid = default_valid(32'(idx));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lk_out_valid <= 1'b0;
    end else begin
      lk_out_valid <= lk_valid;
    end
  end

  branch_lut_mem #(
    .KEY_W  (KEY_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_key   (wr_key),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .rd_en    (lk_valid),
    .rd_blank (state == ST_INIT),
    .rd_key   (lk_key),
    .rd_addr  (lk_addr),
    .rd_hit   (lk_hit)
  );

endmodule

// File: tb/tb_branch_lut.sv
// -----------------------------------------------------------------------------
// tb_branch_lut
//   Directed and randomized stimulus for branch_lut against a table model:
//   the model keeps the table contents as plain arrays, treats a reload as an
//   instant return to the default set that stays hidden (lookups miss) for
//   DEPTH cycles, and applies accepted writes directly.
//   Works with and without BRANCH_LUT_WRITE_EN.
// -----------------------------------------------------------------------------
module tb_branch_lut;

  localparam int KEY_W  = 5;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 32;
  localparam int N_DEF  = 18;

`ifdef BRANCH_LUT_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              lk_valid;
  logic [KEY_W-1:0]  lk_key;
  logic              lk_out_valid;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_hit;
  logic              prog_valid;
  logic              prog_ready;
  logic [KEY_W-1:0]  prog_key;
  logic [ADDR_W-1:0] prog_addr;
  logic              init_req;
  logic              busy;

  always #5 clk = ~clk;

  branch_lut #(
    .KEY_W  (KEY_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .lk_valid     (lk_valid),
    .lk_key       (lk_key),
    .lk_out_valid (lk_out_valid),
    .lk_addr      (lk_addr),
    .lk_hit       (lk_hit),
    .prog_valid   (prog_valid),
    .prog_ready   (prog_ready),
    .prog_key     (prog_key),
    .prog_addr    (prog_addr),
    .init_req     (init_req),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;

  int unsigned defaults [N_DEF] = '{32, 33, 34, 35, 60, 64, 91, 109, 128,
                                    142, 168, 170, 200, 204, 224, 232, 240, 254};

  int unsigned ref_data  [DEPTH];
  bit          ref_valid [DEPTH];
  bit          ref_busy;
  int          init_left;
  bit          exp_ov;
  int unsigned exp_addr;
  bit          exp_hit;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_defaults();
    for (int i = 0; i < DEPTH; i++) begin
      ref_data[i]  = (i < N_DEF) ? defaults[i] : 0;
      ref_valid[i] = (i < N_DEF);
    end
  endtask

  task automatic model_reset();
    ref_busy  = 1'b1;
    init_left = DEPTH;
    load_defaults();
    exp_ov   = 1'b0;
    exp_addr = 0;
    exp_hit  = 1'b0;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic do_reset(input string tag);
    reset_n    = 1'b0;
    lk_valid   = 1'b0;
    lk_key     = '0;
    prog_valid = 1'b0;
    prog_key   = '0;
    prog_addr  = '0;
    init_req   = 1'b0;
    model_reset();
    #1;
    check({tag, ".busy"},     32'(busy),         32'(1));
    check({tag, ".ready"},    32'(prog_ready),   32'(0));
    check({tag, ".ov"},       32'(lk_out_valid), 32'(0));
    check({tag, ".addr"},     32'(lk_addr),      32'(0));
    check({tag, ".hit"},      32'(lk_hit),       32'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check handshake outputs, update the model,
  // clock, then check the registered lookup result.
  task automatic step(input bit lv, input int k, input bit pv, input int pk,
                      input int pa, input bit ir, input string tag);
    bit fire;
    lk_valid   = lv;
    lk_key     = KEY_W'(k);
    prog_valid = pv;
    prog_key   = KEY_W'(pk);
    prog_addr  = ADDR_W'(pa);
    init_req   = ir;
    #1;
    check({tag, ".busy"},  32'(busy),       32'(ref_busy));
    check({tag, ".ready"}, 32'(prog_ready), 32'(WR_EN && !ref_busy && !ir));

    fire = WR_EN && !ref_busy && !ir && pv;
    if (lv) begin
      exp_ov = 1'b1;
      if (ref_busy) begin
        exp_addr = 0;
        exp_hit  = 1'b0;
      end else if (fire && pk == k) begin
        exp_addr = pa;
        exp_hit  = 1'b1;
      end else begin
        exp_hit  = ref_valid[k];
        exp_addr = ref_valid[k] ? ref_data[k] : 0;
      end
    end else begin
      exp_ov = 1'b0;
    end
    if (fire) begin
      ref_data[pk]  = pa;
      ref_valid[pk] = 1'b1;
    end
    if (ref_busy) begin
      init_left--;
      if (init_left == 0) ref_busy = 1'b0;
    end else if (ir) begin
      ref_busy  = 1'b1;
      init_left = DEPTH;
      load_defaults();
    end

    @(posedge clk);
    #1;
    check({tag, ".ov"},   32'(lk_out_valid), 32'(exp_ov));
    check({tag, ".addr"}, 32'(lk_addr),      exp_addr);
    check({tag, ".hit"},  32'(lk_hit),       32'(exp_hit));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int pk;
    reset_n    = 1'b1;
    lk_valid   = 1'b0;
    lk_key     = '0;
    prog_valid = 1'b0;
    prog_key   = '0;
    prog_addr  = '0;
    init_req   = 1'b0;
    #3;
    @(posedge clk);
    #1;
    do_reset("reset");

    // Initial default walk: busy for exactly DEPTH cycles.
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 0, "init_idle");

    step(1, 4,  0, 0, 0, 0, "lk4");
    step(1, 17, 0, 0, 0, 0, "lk17");
    step(0, 0,  0, 0, 0, 0, "hold");
    step(1, 20, 0, 0, 0, 0, "lk20_miss");
    step(0, 0,  1, 20, 8'h55, 0, "wr20");
    step(1, 20, 0, 0, 0, 0, "lk20_new");
    step(1, 5,  1, 5, 8'h10, 0, "fwd5");
    step(1, 5,  0, 0, 0, 0, "lk5_after");

    // Reload while overrides are present; lookups and writes during it.
    step(1, 5, 0, 0, 0, 1, "init_req");
    for (int i = 0; i < DEPTH; i++)
      step(1, i, 1, i, 8'hA5, (i == 7), "reload");
    step(1, 5,  0, 0, 0, 0, "lk5_reloaded");
    step(1, 20, 0, 0, 0, 0, "lk20_reloaded");
    step(1, 31, 0, 0, 0, 0, "lk31_last");
    step(1, 0,  0, 0, 0, 0, "lk0_first");

    // Reset in the middle of a walk restarts it from index 0.
    do_reset("reset2");
    for (int i = 0; i < 10; i++) step(1, i, 0, 0, 0, 0, "walk_a");
    do_reset("reset_mid");
    for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 0, "walk_b");
    step(1, 9, 0, 0, 0, 0, "lk9");

    step(0, 0, 1, 3, 8'hFF, 0, "wr3");
    step(1, 3, 0, 0, 0, 0, "lk3");

    // Randomized traffic with occasional reloads.
    for (int n = 0; n < 500; n++) begin
      k  = int'($urandom_range(0, DEPTH - 1));
      pk = ($urandom_range(0, 3) == 0) ? k : int'($urandom_range(0, DEPTH - 1));
      step($urandom_range(0, 1) == 1, k,
           $urandom_range(0, 1) == 1, pk, int'($urandom_range(0, 255)),
           $urandom_range(0, 79) == 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_lut.md
# branch_lut

Programmable branch-target lookup table for the processor's branch unit. A `KEY_W`-bit key is translated to an `ADDR_W`-bit jump target through a registered read port. The table is loaded with the default target set on every reset and on request. With the write option compiled in, firmware or a debug loader can rewrite entries at run time through a valid/ready port.

## Interface
- `KEY_W`, 5, key width; table depth `DEPTH = 2**KEY_W`
- `ADDR_W`, 8, target address width
- `clk` in 1: single clock, all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `lk_valid` in 1: lookup request
- `lk_key` in KEY_W: lookup key
- `lk_out_valid` out 1: result valid, one cycle after `lk_valid`
- `lk_addr` out ADDR_W: target address; 0 on miss
- `lk_hit` out 1: entry was valid
- `prog_valid` in 1: write request
- `prog_ready` out 1: write accepted when `prog_valid && prog_ready`
- `prog_key` in KEY_W: entry to write
- `prog_addr` in ADDR_W: target to store
- `init_req` in 1: single-cycle pulse; reload defaults
- `busy` out 1: INIT in progress

## Operation
- Storage: `DEPTH` × (`ADDR_W` data + 1 valid bit).
- FSM states:
  - INIT: walks index 0..DEPTH-1, one entry per cycle. Each entry gets the default value and its default valid bit. Exits to IDLE after index DEPTH-1.
  - IDLE: serves lookups and writes.
- Defaults for keys 0..17: 32, 33, 34, 35, 60, 64, 91, 109, 128, 142, 168, 170, 200, 204, 224, 232, 240, 254, all valid. Keys 18..DEPTH-1 default to 0, invalid.
- Lookup in IDLE: the registered result is `lk_addr = valid ? data : 0` and `lk_hit = valid`.
- Lookup during INIT: `lk_out_valid` asserts as normal with `lk_hit = 0` and `lk_addr = 0`. No stall.
- `prog_ready = (state == IDLE) && !init_req`. An accepted write stores `prog_addr` and sets the valid bit.
- Write and lookup to the same key in the same cycle: the lookup returns the new value (write-through forwarding), with `lk_hit = 1`.
- `init_req` while in IDLE: enter INIT next cycle, index restarts at 0. `init_req` while in INIT: ignored.
- Default values narrower than `ADDR_W` are zero-extended. Wider values are truncated to `ADDR_W` LSBs.

## Timing
- Reset values: `lk_out_valid = 0`, `lk_addr = 0`, `lk_hit = 0`, `busy = 1`, `prog_ready = 0`.
- Reset clears all valid bits. The FSM leaves reset in INIT at index 0.
- Reset asserted mid-INIT or mid-operation: everything returns to the reset state, and the walk restarts from 0 after release.
- INIT lasts exactly `DEPTH` cycles. `busy` falls in the cycle in which IDLE is entered.
- Lookup latency: 1 cycle. Back-to-back lookups are accepted every cycle.
- Write latency: visible to a lookup issued in the same cycle (via forwarding) or any later cycle.
- `lk_out_valid` is high for exactly one cycle per request. Outputs hold their last value while `lk_out_valid = 0`.

## Configuration
- `BRANCH_LUT_WRITE_EN` defined: the programming port is functional as described above.
- `BRANCH_LUT_WRITE_EN` undefined:
  - `prog_ready` is tied to 0 and the `prog_*` inputs are ignored.
  - The table is fixed at its defaults; INIT still runs after reset and on `init_req`.
  - Synthesis may reduce the storage to ROM.

## Structure
- Shared package `branch_lut_pkg` holds:
  - `DEFAULT_TARGETS`, a constant array of the 18 defaults
  - `N_DEFAULTS = 18`
  - the FSM state enum `{ST_INIT, ST_IDLE}`
- One sub-module, `branch_lut_mem`: a single-write, single-registered-read storage array including the valid bits and forwarding. The FSM and handshakes live in the top level.

## Test plan
- Reset, then hold idle: `busy` is high for 32 cycles, then low. Lookup key 4 → next cycle `lk_out_valid = 1`, `lk_addr = 60`, `lk_hit = 1`. Key 17 → 254.
- Lookup key 20 after INIT → `lk_hit = 0`, `lk_addr = 0`. Write key 20 = 0x55, then lookup → `lk_addr = 85`, `lk_hit = 1`.
- Same-cycle write key 5 = 0x10 and lookup key 5 → result 0x10, hit. The following lookup of key 5 also returns 0x10.
- After overriding key 5 and key 20:
  - pulse `init_req` → `prog_ready = 0` for that cycle and for the next 32 cycles.
  - lookups during INIT → miss.
  - after INIT: key 5 → 64, key 20 → miss.
- Assert `reset_n` low at INIT index 10 → outputs return to reset values, and after release `busy` lasts a full 32 cycles.
- Build without `BRANCH_LUT_WRITE_EN`: `prog_valid` with key 3 = 0xFF → `prog_ready` stays 0, and lookup key 3 still returns 35.
